// File: rtl/branch_checkpoint_ctrl.sv
// Branch checkpoint controller for the rename map table.
// Each dispatched branch gets a checkpoint slot holding a snapshot of the
// map table (preg mapping plus ready bits). The controller keeps the live
// snapshots coherent with CDB completions. On a mispredict it replays the
// snapshot and reports which branch tags must be squashed.
//
// Ports:
//   clock, reset        - clock; asynchronous active-high reset
//   br_dispatch_valid   - a branch dispatches; snapshot snap_preg/snap_ready
//   br_tag, br_mask     - slot for this cycle's branch; currently valid slots
//   ckpt_full           - no free slot; branch dispatch must stall
//   resolve_*           - branch resolution (tag, mispredict flag)
//   cdb_valid, cdb_preg - per-lane completed physical registers
//   restore_*           - one-cycle map-table restore pulse and its data
//   squash_mask         - tags killed by the mispredict (valid with restore)
//   free_count          - number of unallocated slots
module branch_checkpoint_ctrl #(
  parameter int NUM_CKPT  = 4,
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 6,
  parameter int CDB_W     = 3,
  parameter int TAG_W     = $clog2(NUM_CKPT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          br_dispatch_valid,
  input  logic [ARCH_REGS*PREG_W-1:0]   snap_preg,
  input  logic [ARCH_REGS-1:0]          snap_ready,
  output logic [TAG_W-1:0]              br_tag,
  output logic [NUM_CKPT-1:0]           br_mask,
  output logic                          ckpt_full,
  input  logic                          resolve_valid,
  input  logic [TAG_W-1:0]              resolve_tag,
  input  logic                          resolve_mispredict,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*PREG_W-1:0]       cdb_preg,
  output logic                          restore_valid,
  output logic [ARCH_REGS*PREG_W-1:0]   restore_preg,
  output logic [ARCH_REGS-1:0]          restore_ready,
  output logic [NUM_CKPT-1:0]           squash_mask,
  output logic [$clog2(NUM_CKPT+1)-1:0] free_count
);

  localparam int FC_W = $clog2(NUM_CKPT + 1);

  logic [NUM_CKPT-1:0]         valid_q;
  logic [NUM_CKPT-1:0]         dep_q   [NUM_CKPT];
  logic [ARCH_REGS*PREG_W-1:0] preg_q  [NUM_CKPT];
  logic [ARCH_REGS-1:0]        ready_q [NUM_CKPT];

  logic [ARCH_REGS-1:0] slot_hit [NUM_CKPT];
  logic [ARCH_REGS-1:0] snap_hit;

  logic [FC_W-1:0]     busy_cnt;
  logic                alloc;
  logic                res_ok;
  logic                mis;
  logic [NUM_CKPT-1:0] tag_oh;
  logic [NUM_CKPT-1:0] alloc_oh;
  logic [NUM_CKPT-1:0] sq_mask;
  logic [NUM_CKPT-1:0] kill;
  logic [NUM_CKPT-1:0] alloc_dep;
  logic                found;

  // CDB match per (slot, arch reg) and for the incoming snapshot.
  always_comb begin
    snap_hit = '0;
    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      slot_hit[s] = '0;
    end
    for (int unsigned r = 0; r < ARCH_REGS; r++) begin
      for (int unsigned l = 0; l < CDB_W; l++) begin
        if (cdb_valid[l] &&
            cdb_preg[l*PREG_W +: PREG_W] == snap_preg[r*PREG_W +: PREG_W]) begin
          snap_hit[r] = 1'b1;
        end
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
          if (cdb_valid[l] &&
              cdb_preg[l*PREG_W +: PREG_W] == preg_q[s][r*PREG_W +: PREG_W]) begin
            slot_hit[s][r] = 1'b1;
          end
        end
      end
    end
  end

  // Slot allocation, occupancy and resolve decode.
  always_comb begin
    br_tag   = '0;
    found    = 1'b0;
    busy_cnt = '0;
    for (int unsigned i = 0; i < NUM_CKPT; i++) begin
      if (!found && !valid_q[i]) begin
        br_tag = TAG_W'(i);
        found  = 1'b1;
      end
      busy_cnt = busy_cnt + {{(FC_W-1){1'b0}}, valid_q[i]};
    end
    free_count = FC_W'(NUM_CKPT) - busy_cnt;
    ckpt_full  = (busy_cnt == FC_W'(NUM_CKPT));
    br_mask    = valid_q;

    tag_oh              = '0;
    tag_oh[resolve_tag] = 1'b1;
    res_ok = resolve_valid && !resolve_mispredict && valid_q[resolve_tag];
    mis    = resolve_valid &&  resolve_mispredict && valid_q[resolve_tag];

    // Younger live branches carry the mispredicted tag in their dep mask.
    sq_mask = tag_oh;
    for (int unsigned k = 0; k < NUM_CKPT; k++) begin
      if (valid_q[k] && dep_q[k][resolve_tag]) begin
        sq_mask[k] = 1'b1;
      end
    end

    kill = '0;
    if (res_ok) begin
      kill = tag_oh;
    end else if (mis) begin
      kill = sq_mask;
    end

    // A mispredict drops any same-cycle dispatch, even on an invalid tag.
    alloc    = br_dispatch_valid && !ckpt_full && !(resolve_valid && resolve_mispredict);
    alloc_oh = '0;
    if (alloc) begin
      alloc_oh[br_tag] = 1'b1;
    end
    alloc_dep = valid_q & ~kill;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      restore_valid <= 1'b0;
      restore_preg  <= '0;
      restore_ready <= '0;
      squash_mask   <= '0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        dep_q[s]   <= '0;
        preg_q[s]  <= '0;
        ready_q[s] <= '0;
      end
    end else begin
      valid_q <= (valid_q & ~kill) | alloc_oh;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        if (alloc_oh[s]) begin
          dep_q[s]   <= alloc_dep;
          preg_q[s]  <= snap_preg;
          ready_q[s] <= snap_ready | snap_hit;
        end else begin
          dep_q[s] <= dep_q[s] & ~kill;
          if (valid_q[s]) begin
            ready_q[s] <= ready_q[s] | slot_hit[s];
          end
        end
      end
      restore_valid <= mis;
      squash_mask   <= mis ? sq_mask : '0;
      if (mis) begin
        restore_preg  <= preg_q[resolve_tag];
        restore_ready <= ready_q[resolve_tag] | slot_hit[resolve_tag];
      end
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
module tb_branch_checkpoint_ctrl;

  logic         clock;
  logic         reset;
  logic         br_dispatch_valid;
  logic [191:0] snap_preg;
  logic [31:0]  snap_ready;
  logic [1:0]   br_tag;
  logic [3:0]   br_mask;
  logic         ckpt_full;
  logic         resolve_valid;
  logic [1:0]   resolve_tag;
  logic         resolve_mispredict;
  logic [2:0]   cdb_valid;
  logic [17:0]  cdb_preg;
  logic         restore_valid;
  logic [191:0] restore_preg;
  logic [31:0]  restore_ready;
  logic [3:0]   squash_mask;
  logic [2:0]   free_count;

  int checks = 0;
  int errors = 0;

  branch_checkpoint_ctrl #(
    .NUM_CKPT (4),
    .ARCH_REGS(32),
    .PREG_W   (6),
    .CDB_W    (3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .br_dispatch_valid (br_dispatch_valid),
    .snap_preg         (snap_preg),
    .snap_ready        (snap_ready),
    .br_tag            (br_tag),
    .br_mask           (br_mask),
    .ckpt_full         (ckpt_full),
    .resolve_valid     (resolve_valid),
    .resolve_tag       (resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .cdb_valid         (cdb_valid),
    .cdb_preg          (cdb_preg),
    .restore_valid     (restore_valid),
    .restore_preg      (restore_preg),
    .restore_ready     (restore_ready),
    .squash_mask       (squash_mask),
    .free_count        (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    br_dispatch_valid  = 1'b0;
    resolve_valid      = 1'b0;
    resolve_tag        = 2'd0;
    resolve_mispredict = 1'b0;
    cdb_valid          = 3'b000;
    cdb_preg           = '0;
  endtask

  // arch reg r maps to preg (r + base) mod 64, all ready
  task automatic set_snap(input int unsigned base);
    for (int unsigned r = 0; r < 32; r++) begin
      snap_preg[r*6 +: 6] = 6'((r + base) % 64);
    end
    snap_ready = '1;
  endtask

  task automatic apply_reset();
    idle();
    set_snap(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    set_snap(0);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL reset_free_count: got %0d expected 4", free_count); end
      checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_ckpt_full: got %b expected 0", ckpt_full); end
      checks++; if (br_tag !== 2'd0) begin errors++; $display("FAIL reset_br_tag: got %0d expected 0", br_tag); end
      checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL reset_restore_valid: got %b expected 0", restore_valid); end
    end
    checks++; if (squash_mask !== 4'b0000 || restore_preg !== 192'd0 || restore_ready !== 32'd0) begin
      errors++; $display("FAIL reset_restore_data: squash %b ready %h expected zeros", squash_mask, restore_ready); end
    reset = 1'b0;
    tick();
    checks++; if (restore_valid !== 1'b0 || br_mask !== 4'b0000) begin
      errors++; $display("FAIL reset_idle: restore_valid %b br_mask %b expected 0/0000", restore_valid, br_mask); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      idle();
      set_snap(0);
      br_dispatch_valid = 1'b1;
      #1;
      checks++; if (br_tag !== 2'(i)) begin errors++; $display("FAIL fill_br_tag: got %0d expected %0d", br_tag, i); end
      tick();
    end
    idle();
    #1;
    checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", ckpt_full); end
    checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL fill_free_count: got %0d expected 0", free_count); end
    br_dispatch_valid = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (free_count !== 3'd0 || br_mask !== 4'b1111) begin
      errors++; $display("FAIL fill_fifth_ignored: free %0d mask %b expected 0/1111", free_count, br_mask); end
    checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL fill_no_restore: got %b expected 0", restore_valid); end
  endtask

  task automatic test_cdb_restore();
    apply_reset();
    // arch3 -> preg33, not ready; woken by CDB lane1 next cycle
    set_snap(0);
    snap_preg[3*6 +: 6] = 6'd33;
    snap_ready[3] = 1'b0;
    br_dispatch_valid = 1'b1;
    #1;
    checks++; if (br_tag !== 2'd0) begin errors++; $display("FAIL cdb_alloc_tag: got %0d expected 0", br_tag); end
    tick();
    idle();
    cdb_valid = 3'b010;
    cdb_preg  = {6'd0, 6'd33, 6'd0};
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0;
    tick();
    idle();
    checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL cdb_restore_pulse: got %b expected 1", restore_valid); end
    checks++; if (restore_preg[3*6 +: 6] !== 6'd33) begin errors++; $display("FAIL cdb_restore_preg3: got %0d expected 33", restore_preg[3*6 +: 6]); end
    checks++; if (restore_preg[5*6 +: 6] !== 6'd5) begin errors++; $display("FAIL cdb_restore_preg5: got %0d expected 5", restore_preg[5*6 +: 6]); end
    checks++; if (restore_ready !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cdb_restore_ready: got %h expected ffffffff", restore_ready); end
    checks++; if (squash_mask !== 4'b0001) begin errors++; $display("FAIL cdb_squash: got %b expected 0001", squash_mask); end
    #1;
    checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL cdb_free_after: got %0d expected 4", free_count); end
    tick();
    checks++; if (restore_valid !== 1'b0 || squash_mask !== 4'b0000) begin
      errors++; $display("FAIL cdb_pulse_end: valid %b squash %b expected 0/0000", restore_valid, squash_mask); end

    // CDB hits in the mispredict cycle; lanes 0 and 2 hit, lane1 invalid
    set_snap(0);
    snap_preg[7*6 +: 6]  = 6'd40;
    snap_preg[9*6 +: 6]  = 6'd41;
    snap_preg[11*6 +: 6] = 6'd42;
    snap_ready[7] = 1'b0; snap_ready[9] = 1'b0; snap_ready[11] = 1'b0;
    br_dispatch_valid = 1'b1;
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0;
    cdb_valid = 3'b101;
    cdb_preg  = {6'd41, 6'd42, 6'd40};
    tick();
    idle();
    checks++; if (restore_ready !== 32'hFFFF_F7FF) begin errors++; $display("FAIL cdb_same_cycle_ready: got %h expected fffff7ff", restore_ready); end
    checks++; if (restore_preg[7*6 +: 6] !== 6'd40) begin errors++; $display("FAIL cdb_same_cycle_preg7: got %0d expected 40", restore_preg[7*6 +: 6]); end
    tick();
  endtask

  task automatic test_squash();
    apply_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      idle();
      set_snap(16 * i);
      br_dispatch_valid = 1'b1;
      tick();
    end
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd1;
    tick();
    idle();
    checks++; if (restore_valid !== 1'b1) begin errors++; $display("FAIL squash_pulse: got %b expected 1", restore_valid); end
    checks++; if (squash_mask !== 4'b0110) begin errors++; $display("FAIL squash_mask: got %b expected 0110", squash_mask); end
    checks++; if (restore_preg[0 +: 6] !== 6'd16 || restore_preg[31*6 +: 6] !== 6'd47) begin
      errors++; $display("FAIL squash_restore_preg: arch0 %0d arch31 %0d expected 16/47", restore_preg[0 +: 6], restore_preg[31*6 +: 6]); end
    #1;
    checks++; if (br_mask !== 4'b0001) begin errors++; $display("FAIL squash_valid: got %b expected 0001", br_mask); end
    checks++; if (free_count !== 3'd3) begin errors++; $display("FAIL squash_free: got %0d expected 3", free_count); end
    tick();
  endtask

  task automatic test_resolve_dispatch();
    apply_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      idle();
      set_snap(i);
      br_dispatch_valid = 1'b1;
      tick();
    end
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_tag = 2'd0;
    br_dispatch_valid = 1'b1;
    #1;
    checks++; if (br_tag !== 2'd3) begin errors++; $display("FAIL rd_new_tag: got %0d expected 3", br_tag); end
    tick();
    idle();
    #1;
    checks++; if (br_mask !== 4'b1110 || free_count !== 3'd1) begin
      errors++; $display("FAIL rd_after: mask %b free %0d expected 1110/1", br_mask, free_count); end
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0;
    tick();
    idle();
    checks++; if (restore_valid !== 1'b0 || squash_mask !== 4'b0000) begin
      errors++; $display("FAIL rd_invalid_mispredict: valid %b squash %b expected 0/0000", restore_valid, squash_mask); end
    #1;
    checks++; if (free_count !== 3'd1) begin errors++; $display("FAIL rd_invalid_free: got %0d expected 1", free_count); end
    br_dispatch_valid = 1'b1;
    #1;
    checks++; if (br_tag !== 2'd0) begin errors++; $display("FAIL rd_reuse_tag: got %0d expected 0", br_tag); end
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0;
    tick();
    idle();
    checks++; if (squash_mask !== 4'b0001 || restore_valid !== 1'b1) begin
      errors++; $display("FAIL rd_dep_excludes_old: squash %b valid %b expected 0001/1", squash_mask, restore_valid); end
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd1;
    tick();
    idle();
    checks++; if (squash_mask !== 4'b1110 || restore_valid !== 1'b1) begin
      errors++; $display("FAIL rd_back_to_back: squash %b valid %b expected 1110/1", squash_mask, restore_valid); end
    #1;
    checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL rd_final_free: got %0d expected 4", free_count); end
    tick();
    checks++; if (restore_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_end: got %b expected 0", restore_valid); end
  endtask

  task automatic test_mispredict_dispatch();
    apply_reset();
    // tag0: arch5 -> preg50 not ready, woken by CDB in the allocation cycle
    set_snap(0);
    snap_preg[5*6 +: 6] = 6'd50;
    snap_ready[5] = 1'b0;
    br_dispatch_valid = 1'b1;
    cdb_valid = 3'b001;
    cdb_preg  = {6'd0, 6'd0, 6'd50};
    tick();
    idle();
    set_snap(8);
    br_dispatch_valid = 1'b1;
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd1;
    br_dispatch_valid = 1'b1;
    #1;
    checks++; if (br_tag !== 2'd2) begin errors++; $display("FAIL md_comb_tag: got %0d expected 2", br_tag); end
    tick();
    idle();
    checks++; if (squash_mask !== 4'b0010 || restore_valid !== 1'b1) begin
      errors++; $display("FAIL md_squash: squash %b valid %b expected 0010/1", squash_mask, restore_valid); end
    #1;
    checks++; if (free_count !== 3'd3 || br_mask !== 4'b0001) begin
      errors++; $display("FAIL md_dispatch_dropped: free %0d mask %b expected 3/0001", free_count, br_mask); end
    tick();
    br_dispatch_valid = 1'b1;
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0;
    tick();
    idle();
    checks++; if (restore_valid !== 1'b1 || squash_mask !== 4'b0011) begin
      errors++; $display("FAIL md_second_restore: valid %b squash %b expected 1/0011", restore_valid, squash_mask); end
    checks++; if (restore_ready !== 32'hFFFF_FFFF || restore_preg[5*6 +: 6] !== 6'd50) begin
      errors++; $display("FAIL md_alloc_cdb: ready %h preg5 %0d expected ffffffff/50", restore_ready, restore_preg[5*6 +: 6]); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (restore_valid !== 1'b0 || squash_mask !== 4'b0000) begin
      errors++; $display("FAIL md_async_reset: valid %b squash %b expected 0/0000", restore_valid, squash_mask); end
    checks++; if (restore_preg !== 192'd0 || restore_ready !== 32'd0 || free_count !== 3'd4) begin
      errors++; $display("FAIL md_async_reset_state: ready %h free %0d expected 0/4", restore_ready, free_count); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_snap(0);
    test_reset();
    test_fill();
    test_cdb_restore();
    test_squash();
    test_resolve_dispatch();
    test_mispredict_dispatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
